// File: rtl/two_d_pkg.sv
// Shared types and helpers for the 2D direction datapath: component widths,
// the denormalizer FSM state encoding, and sign-magnitude conversion.
package two_d_pkg;

    localparam int COMP_W  = 11;
    localparam int MAG_W   = 10;
    localparam int DIR_W   = 22;
    localparam int D_W     = 8;
    localparam int MAG_MAX = (1 << MAG_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_X,
        S_DIV_Y,
        S_DONE
    } denorm_state_t;

    // A negative sign on a zero magnitude collapses to plain zero.
    function automatic logic [COMP_W-1:0] sm_to_tc(input logic sign,
                                                   input logic [MAG_W-1:0] mag);
        logic [COMP_W-1:0] ext;
        ext = {1'b0, mag};
        if (mag == '0)
            return '0;
        return sign ? (~ext + COMP_W'(1)) : ext;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider producing one quotient bit per clock; the start
// cycle already performs the first step, so a divide takes exactly W cycles.
module serial_divider #(
    parameter int W  = 18,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  rem_in;
    logic [W-1:0]  quo_in;
    logic [W:0]    trial;
    logic [W-1:0]  dvs_ext;
    logic          fits;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  quo_nxt;

    // NOTE: every variable gets a value at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_ext = W'(divisor);
        trial   = {rem_in, quo_in[W-1]};
        fits    = trial >= {1'b0, dvs_ext};
        // When the trial fits, the difference is below the divisor, so the
        // low W bits hold it exactly.
        rem_nxt = fits ? (trial[W-1:0] - dvs_ext) : trial[W-1:0];
        quo_nxt = {quo_in[W-2:0], fits};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= CW'(W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/two_d_denormalize.sv
// Rescales a sign-magnitude normalized direction of length d to length len,
// packing {x, y} as 11-bit two's complement. Define TWO_D_DENORM_ROUND_EN for
// round-half-up magnitudes instead of truncation.
module two_d_denormalize
    import two_d_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COMP_W-1:0]  norm_x,
    input  logic [COMP_W-1:0]  norm_y,
    input  logic [D_W-1:0]     d,
    input  logic [LEN_W-1:0]   len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIR_W-1:0]   dir,
    output logic               err
);

    localparam int PROD_W = MAG_W + LEN_W;

    denorm_state_t       state_q;
    logic                sx_q;
    logic                sy_q;
    logic [D_W-1:0]      d_q;
    logic [PROD_W-1:0]   px_q;
    logic [PROD_W-1:0]   py_q;
    logic [COMP_W-1:0]   x_tc_q;

    logic                div_start;
    logic                div_busy;
    logic                div_done;
    logic [PROD_W-1:0]   div_dividend;
    logic [PROD_W-1:0]   div_quo;
    logic [PROD_W-1:0]   bias;

`ifdef TWO_D_DENORM_ROUND_EN
    assign bias = PROD_W'(d_q >> 1);
`else
    assign bias = '0;
`endif

    function automatic logic [MAG_W-1:0] sat_mag(input logic [PROD_W-1:0] q);
        return (q > PROD_W'(MAG_MAX)) ? MAG_W'(MAG_MAX) : q[MAG_W-1:0];
    endfunction

    // x is launched from MUL, y back-to-back on the cycle x completes.
    assign div_start    = !div_busy &&
                          (((state_q == S_MUL) && (d_q != '0)) ||
                           ((state_q == S_DIV_X) && div_done));
    assign div_dividend = ((state_q == S_MUL) ? px_q : py_q) + bias;

    serial_divider #(
        .W  (PROD_W),
        .DW (D_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (d_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dir       <= '0;
            err       <= 1'b0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            d_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            x_tc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sx_q     <= norm_x[COMP_W-1];
                        sy_q     <= norm_y[COMP_W-1];
                        d_q      <= d;
                        px_q     <= PROD_W'(norm_x[MAG_W-1:0]) * PROD_W'(len);
                        py_q     <= PROD_W'(norm_y[MAG_W-1:0]) * PROD_W'(len);
                        in_ready <= 1'b0;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (d_q == '0) begin
                        dir       <= '0;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        state_q <= S_DIV_X;
                    end
                end
                S_DIV_X: begin
                    if (div_done) begin
                        x_tc_q  <= sm_to_tc(sx_q, sat_mag(div_quo));
                        state_q <= S_DIV_Y;
                    end
                end
                S_DIV_Y: begin
                    if (div_done) begin
                        dir       <= {x_tc_q, sm_to_tc(sy_q, sat_mag(div_quo))};
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_two_d_denormalize.sv
// Directed bench for two_d_denormalize: latency, saturation, divide-by-zero,
// rounding, negative zero, backpressure, mid-operation reset and throughput.
module tb_two_d_denormalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] norm_x;
    logic [10:0] norm_y;
    logic [7:0]  d;
    logic [7:0]  len;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] dir;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    two_d_denormalize #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .norm_x    (norm_x),
        .norm_y    (norm_y),
        .d         (d),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dir       (dir),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one request and return just after its accept edge.
    task automatic send(input logic [10:0] nx, input logic [10:0] ny,
                        input logic [7:0] dd, input logic [7:0] ll);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        norm_x   = nx;
        norm_y   = ny;
        d        = dd;
        len      = ll;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles from the accept edge (counted as 1) until out_valid is seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          t_first;
        int          t_second;
        logic [21:0] held_dir;
        logic [21:0] exp_round;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        norm_x    = '0;
        norm_y    = '0;
        d         = '0;
        len       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_dir", 32'(dir), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // x=+100, y=-50, d=100, len=200 -> {200, -100}
        send(11'd100, 11'h432, 8'd100, 8'd200);
        wait_valid(lat);
        check("basic_latency", 32'(lat), 32'd38);
        check("basic_dir", 32'(dir), 32'({11'd200, 11'h79C}));
        check("basic_err", 32'(err), 32'd0);
        take_result();

        // Divide by zero short-circuits to DONE.
        send(11'h123, 11'h456, 8'd0, 8'd9);
        wait_valid(lat);
        check("div0_latency", 32'(lat), 32'd2);
        check("div0_dir", 32'(dir), 32'd0);
        check("div0_err", 32'(err), 32'd1);
        take_result();

        // x=+1000*255/10 saturates; err clears after the div0 result.
        send(11'd1000, 11'd0, 8'd10, 8'd255);
        wait_valid(lat);
        check("sat_latency", 32'(lat), 32'd38);
        check("sat_dir", 32'(dir), 32'({11'd1023, 11'd0}));
        check("sat_err", 32'(err), 32'd0);
        take_result();

        // 1.5 magnitudes: truncate to 1 or round up to 2.
`ifdef TWO_D_DENORM_ROUND_EN
        exp_round = {11'd2, 11'h7FE};
`else
        exp_round = {11'd1, 11'h7FF};
`endif
        send(11'd1, 11'h401, 8'd2, 8'd3);
        wait_valid(lat);
        check("round_latency", 32'(lat), 32'd38);
        check("round_dir", 32'(dir), 32'(exp_round));
        take_result();

        // -0 input and -3*1/10 -> 0 in both builds: no negative zero.
        send(11'h400, 11'h403, 8'd10, 8'd1);
        wait_valid(lat);
        check("negzero_dir", 32'(dir), 32'd0);
        check("negzero_err", 32'(err), 32'd0);
        take_result();

        // Backpressure: x=-512, y=+256, d=128, len=64 -> {-256, 128}
        send(11'h600, 11'd256, 8'd128, 8'd64);
        wait_valid(lat);
        check("bp_dir", 32'(dir), 32'({11'h700, 11'd128}));
        held_dir = 22'h0;
        held_dir = {11'h700, 11'd128};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            norm_x   = 11'd7;
            norm_y   = 11'd9;
            d        = 8'd1;
            len      = 8'd1;
            in_valid = 1'b1;
            check("bp_dir_stable", 32'(dir), 32'(held_dir));
            check("bp_err_stable", 32'(err), 32'd0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take_result();
        repeat (3) @(negedge clk);
        check("bp_no_ghost_valid", 32'(out_valid), 32'd0);
        check("bp_no_ghost_ready", 32'(in_ready), 32'd1);

        // out_ready while idle must not produce anything.
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_out_ready_no_effect", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset during DIV_X, in the fifth cycle after accept.
        send(11'd100, 11'h432, 8'd100, 8'd200);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_dir", 32'(dir), 32'd0);

        // x=+300, y=+7, d=50, len=100 -> {600, 14}
        send(11'd300, 11'd7, 8'd50, 8'd100);
        wait_valid(lat);
        check("post_reset_latency", 32'(lat), 32'd38);
        check("post_reset_dir", 32'(dir), 32'({11'd600, 11'd14}));
        take_result();

        // Throughput with out_ready tied high: accept-to-accept spacing.
        @(negedge clk);
        norm_x    = 11'd100;
        norm_y    = 11'h432;
        d         = 8'd100;
        len       = 8'd200;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t_first   = -1;
        t_second  = -1;
        cyc       = 0;
        while (t_second < 0 && cyc < 150) begin
            if (in_ready) begin
                if (t_first < 0)
                    t_first = cyc;
                else
                    t_second = cyc;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("throughput_period", 32'(t_second - t_first), 32'd39);
        repeat (45) @(posedge clk);
        #1 check("throughput_drained", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
